// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES controller that runs an initial AddRoundKey and then
// NR passes through an external single-round datapath, returning the block on valid/ready.
module aes_round_sequencer #(
   parameter int NR       = 10,
   parameter int RK_IDX_W = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic                i_mode,
   input  logic [127:0]        i_din,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [127:0]        o_dout,
   output logic                o_busy,
   output logic [RK_IDX_W-1:0] o_rk_idx,
   input  logic [127:0]        i_rk,
   output logic [127:0]        o_rf_state,
   output logic                o_rf_inv,
   output logic                o_rf_last,
   input  logic [127:0]        i_rf_result
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
   localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);
   fsm_t                fsm, fsm_nxt;
   logic [127:0]        state, state_nxt;
   logic [RK_IDX_W-1:0] rnd, rnd_nxt;
   logic                mode, mode_nxt;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fsm   <= IDLE;
         state <= '0;
         rnd   <= '0;
         mode  <= 1'b0;
      end else begin
         fsm   <= fsm_nxt;
         state <= state_nxt;
         rnd   <= rnd_nxt;
         mode  <= mode_nxt;
      end
   end
   // decrypt walks the schedule backwards: key NR up front, then NR-1 down to 0
   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      rnd_nxt   = rnd;
      mode_nxt  = mode;
      o_ready   = fsm == IDLE;
      o_valid   = fsm == DONE;
      o_busy    = fsm != IDLE;
      o_rf_last = fsm == RUN && rnd == NR_IDX;
      o_rk_idx  = fsm == IDLE ? (i_mode ? NR_IDX : '0) : (mode ? NR_IDX - rnd : rnd);
      case (fsm)
         IDLE: if (i_valid) begin
            state_nxt = i_din ^ i_rk;
            mode_nxt  = i_mode;
            rnd_nxt   = RK_IDX_W'(1);
            fsm_nxt   = RUN;
         end
         RUN: begin
            state_nxt = i_rf_result;
            if (o_rf_last) fsm_nxt = DONE;
            else rnd_nxt = rnd + 1'b1;
         end
         DONE: if (i_ready) fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end
   assign o_dout     = state;
   assign o_rf_state = state;
   assign o_rf_inv   = mode;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: drives NR=10 and NR=14 sequencers against a behavioural AES round
// and key schedule, checking results through a scoreboard plus per-cycle index/flag checks.
module tb_aes_round_sequencer;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;
   int total = 0, bad = 0;
   logic         a_valid, a_ready, a_mode, a_ovalid, a_iready, a_busy, a_rf_inv, a_rf_last;
   logic [127:0] a_din, a_dout, a_rk, a_rf_state, a_rf_result;
   logic [3:0]   a_rk_idx;
   logic         b_valid, b_ready, b_mode, b_ovalid, b_iready, b_busy, b_rf_inv, b_rf_last;
   logic [127:0] b_din, b_dout, b_rk, b_rf_state, b_rf_result;
   logic [3:0]   b_rk_idx;
   logic [127:0] rk128 [16];
   logic [127:0] rk256 [16];
   logic [127:0] a_q [$];
   logic [127:0] b_q [$];

   aes_round_sequencer #(.NR(10), .RK_IDX_W(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready), .i_mode(a_mode),
      .i_din(a_din), .o_valid(a_ovalid), .i_ready(a_iready), .o_dout(a_dout), .o_busy(a_busy),
      .o_rk_idx(a_rk_idx), .i_rk(a_rk), .o_rf_state(a_rf_state), .o_rf_inv(a_rf_inv),
      .o_rf_last(a_rf_last), .i_rf_result(a_rf_result));
   aes_round_sequencer #(.NR(14), .RK_IDX_W(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready), .i_mode(b_mode),
      .i_din(b_din), .o_valid(b_ovalid), .i_ready(b_iready), .o_dout(b_dout), .o_busy(b_busy),
      .o_rk_idx(b_rk_idx), .i_rk(b_rk), .o_rf_state(b_rf_state), .o_rf_inv(b_rf_inv),
      .o_rf_last(b_rf_last), .i_rf_result(b_rf_result));

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (i != 0) r = gmul(r, a);
      end
      return r;
   endfunction
   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
   endfunction
   function automatic logic [7:0] isbox(input logic [7:0] a);
      return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
   endfunction
   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
   endfunction
   // one cipher round (or inverse round) including AddRoundKey, byte 0 in [127:120]
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic inv, input logic last);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[r+4*c] = inv ? isbox(a[r+4*((c+4-r)%4)]) : sbox(a[r+4*((c+r)%4)]);
      if (inv) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
         if (last) for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
         else if (inv) begin
            a[4*c]   = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
            a[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
            a[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
            a[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
         end else begin
            a[4*c]   = gmul(b[4*c],8'h02) ^ gmul(b[4*c+1],8'h03) ^ b[4*c+2] ^ b[4*c+3];
            a[4*c+1] = b[4*c] ^ gmul(b[4*c+1],8'h02) ^ gmul(b[4*c+2],8'h03) ^ b[4*c+3];
            a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2],8'h02) ^ gmul(b[4*c+3],8'h03);
            a[4*c+3] = gmul(b[4*c],8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3],8'h02);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
      return inv ? o : o ^ k;
   endfunction
   function automatic logic [127:0] aes_enc128(input logic [127:0] blk);
      logic [127:0] s;
      s = blk ^ rk128[0];
      for (int r = 1; r <= 10; r++) s = aes_round(s, rk128[r], 1'b0, r == 10);
      return s;
   endfunction

   assign a_rk        = rk128[a_rk_idx];
   assign b_rk        = rk256[b_rk_idx];
   assign a_rf_result = aes_round(a_rf_state, a_rk, a_rf_inv, a_rf_last);
   assign b_rf_result = aes_round(b_rf_state, b_rk, b_rf_inv, b_rf_last);

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit big);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0] rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++)
         if (big) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask
   task automatic send(input bit sel, input logic [127:0] d, input logic m, input logic [127:0] e,
                       input bit keep, output int t);
      int n = 0;
      if (sel) begin b_q.push_back(e); b_din = d; b_mode = m; b_valid = 1'b1; end
      else begin a_q.push_back(e); a_din = d; a_mode = m; a_valid = 1'b1; end
      @(negedge clk);
      while (!(sel ? b_ready : a_ready) && n < 100) begin @(negedge clk); n++; end
      t = cyc;
      if (n >= 100) chk("accept_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
      if (!keep) begin if (sel) b_valid = 1'b0; else a_valid = 1'b0; end
   endtask
   task automatic drain(input bit sel);
      int n = 0;
      @(negedge clk);
      while ((sel ? (b_q.size() != 0 || !b_ready) : (a_q.size() != 0 || !a_ready)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
   endtask
   task automatic wait_valid_a();
      int n = 0;
      while (!a_ovalid && n < 50) begin @(negedge clk); n++; end
      chk("a_valid_seen", 128'(a_ovalid), 128'd1);
   endtask

   int a_k = 0, a_t = 0, b_k = 0, b_t = 0;
   logic a_m = 1'b0, a_pv = 1'b0, b_m = 1'b0, b_pv = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            chk("a_idx_accept", 128'(a_rk_idx), a_mode ? 128'd10 : 128'd0);
            a_t = cyc; a_k = 1; a_m = a_mode;
         end else if (a_busy && !a_ovalid) begin
            chk("a_idx_run", 128'(a_rk_idx), 128'(a_m ? 10 - a_k : a_k));
            chk("a_last", 128'(a_rf_last), 128'(a_k == 10));
            chk("a_inv", 128'(a_rf_inv), 128'(a_m));
            a_k++;
         end else chk("a_last_idle", 128'(a_rf_last), 128'd0);
         if (a_ovalid && !a_pv) chk("a_latency", 128'(cyc - a_t), 128'd11);
         if (a_ovalid && a_iready) begin
            if (a_q.size() == 0) chk("a_sb_empty", 128'd1, 128'd0);
            else chk("a_dout", a_dout, a_q.pop_front());
         end
      end
      a_pv = a_ovalid;
   end
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_valid && b_ready) begin
            chk("b_idx_accept", 128'(b_rk_idx), b_mode ? 128'd14 : 128'd0);
            b_t = cyc; b_k = 1; b_m = b_mode;
         end else if (b_busy && !b_ovalid) begin
            chk("b_idx_run", 128'(b_rk_idx), 128'(b_m ? 14 - b_k : b_k));
            chk("b_last", 128'(b_rf_last), 128'(b_k == 14));
            b_k++;
         end
         if (b_ovalid && !b_pv) chk("b_latency", 128'(cyc - b_t), 128'd15);
         if (b_ovalid && b_iready) begin
            if (b_q.size() == 0) chk("b_sb_empty", 128'd1, 128'd0);
            else chk("b_dout", b_dout, b_q.pop_front());
         end
      end
      b_pv = b_ovalid;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2;
      logic [127:0] rb;
      a_valid = 0; a_mode = 0; a_din = '0; a_iready = 1;
      b_valid = 0; b_mode = 0; b_din = '0; b_iready = 1;
      for (int i = 0; i < 16; i++) begin rk128[i] = '0; rk256[i] = '0; end
      expand({K128, 128'h0}, 4, 10, 1'b0);
      expand(K256, 8, 14, 1'b1);
      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(a_ready), 128'd1);
      chk("rst_valid", 128'(a_ovalid), 128'd0);
      chk("rst_busy", 128'(a_busy), 128'd0);
      chk("rst_dout", a_dout, 128'd0);
      chk("rst_last", 128'(a_rf_last), 128'd0);
      chk("rst_inv", 128'(a_rf_inv), 128'd0);
      chk("rst_idx", 128'(a_rk_idx), 128'd0);
      chk("rst_b_ready", 128'(b_ready), 128'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      send(1'b0, PT, 1'b0, CT1, 1'b0, t1);
      drain(1'b0);
      send(1'b0, CT1, 1'b1, PT, 1'b0, t1);
      drain(1'b0);
      // result held under back-pressure while stray i_valid pulses are ignored
      a_iready = 1'b0;
      send(1'b0, PT, 1'b0, CT1, 1'b0, t1);
      wait_valid_a();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         a_valid = (i % 2 == 0);
         a_din = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("bp_valid", 128'(a_ovalid), 128'd1);
         chk("bp_dout", a_dout, CT1);
         chk("bp_ready", 128'(a_ready), 128'd0);
      end
      @(posedge clk); #1 a_valid = 1'b0; a_iready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_ready", 128'(a_ready), 128'd1);
      chk("bp_idle_valid", 128'(a_ovalid), 128'd0);
      @(posedge clk); #1;
      rb = {$urandom, $urandom, $urandom, $urandom};
      send(1'b0, PT, 1'b0, CT1, 1'b1, t1);
      send(1'b0, rb, 1'b0, aes_enc128(rb), 1'b0, t2);
      chk("b2b_gap", 128'(t2 - t1), 128'd12);
      drain(1'b0);
      send(1'b0, PT, 1'b0, CT1, 1'b0, t1);
      repeat (4) @(posedge clk);
      #2 chk("rst_run_busy_pre", 128'(a_busy), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", 128'(a_busy), 128'd0);
      chk("rst_run_valid", 128'(a_ovalid), 128'd0);
      a_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      send(1'b0, PT, 1'b0, CT1, 1'b0, t1);
      drain(1'b0);
      a_iready = 1'b0;
      send(1'b0, PT, 1'b0, CT1, 1'b0, t1);
      wait_valid_a();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done_valid", 128'(a_ovalid), 128'd0);
      chk("rst_done_dout", a_dout, 128'd0);
      a_q.delete();
      @(posedge clk); #1 rst_n = 1'b1; a_iready = 1'b1;
      send(1'b1, PT, 1'b0, CT3, 1'b0, t1);
      drain(1'b1);
      send(1'b1, CT3, 1'b1, PT, 1'b0, t1);
      drain(1'b1);
      chk("a_sb_left", 128'(a_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
